// File: rtl/pll_power_sequencer.sv
// PLL power sequencer: keeps the DCS on spi_clock whenever the PLL may be unstable,
// powers the PLL down/up on request and recovers from lock loss or lock timeout.
module pll_power_sequencer #(
    parameter int unsigned SWITCH_CYCLES = 8,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned LOCK_TIMEOUT  = 4096
) (
    input  logic       osc_clock_in,
    input  logic       pll_reset,
    input  logic       powerdown_req_in,
    input  logic       read_req_in,
    input  logic       pll_locked_in,
    output logic       pllpowerdown_n_out,
    output logic       clock_select_out,
    output logic       ready_out,
    output logic       lock_error_out,
    output logic [2:0] state_out
);

    localparam int unsigned MAX_AB  = (SWITCH_CYCLES > SETTLE_CYCLES) ? SWITCH_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SWITCH_LAST  = CNT_W'(SWITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        RUN           = 3'd0,
        SWITCH_TO_SPI = 3'd1,
        SPI_HOLD      = 3'd2,
        POWER_DOWN    = 3'd3,
        OFF           = 3'd4,
        POWER_UP      = 3'd5,
        LOCK_SETTLE   = 3'd6,
        SWITCH_BACK   = 3'd7
    } state_e;

    // Reset asserts immediately, releases on the second clock edge after pll_reset drops.
    logic rst_meta_q, rst_q;
    always_ff @(posedge osc_clock_in or posedge pll_reset) begin
        if (pll_reset) begin
            rst_meta_q <= 1'b1;
            rst_q      <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_q      <= rst_meta_q;
        end
    end

    logic pd_meta_q, pd_q, rd_meta_q, rd_q, lk_meta_q, lk_q;
    always_ff @(posedge osc_clock_in or posedge rst_q) begin
        if (rst_q) begin
            pd_meta_q <= 1'b0;
            pd_q      <= 1'b0;
            rd_meta_q <= 1'b0;
            rd_q      <= 1'b0;
            lk_meta_q <= 1'b0;
            lk_q      <= 1'b0;
        end else begin
            pd_meta_q <= powerdown_req_in;
            pd_q      <= pd_meta_q;
            rd_meta_q <= read_req_in;
            rd_q      <= rd_meta_q;
            lk_meta_q <= pll_locked_in;
            lk_q      <= lk_meta_q;
        end
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pllpowerdown_n_q, pllpowerdown_n_d;
    logic             clock_select_q, clock_select_d;
    logic             ready_q, ready_d;
    logic             lock_error_q, lock_error_d;

    always_ff @(posedge osc_clock_in or posedge rst_q) begin
        if (rst_q) begin
            state_q          <= POWER_UP;
            cnt_q            <= '0;
            pllpowerdown_n_q <= 1'b1;
            clock_select_q   <= 1'b1;
            ready_q          <= 1'b0;
            lock_error_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            pllpowerdown_n_q <= pllpowerdown_n_d;
            clock_select_q   <= clock_select_d;
            ready_q          <= ready_d;
            lock_error_q     <= lock_error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lock_error_d = lock_error_q;

        unique case (state_q)
            RUN: begin
                if (pd_q || rd_q)  state_d = SWITCH_TO_SPI;
                else if (!lk_q)    state_d = POWER_UP;
            end
            SWITCH_TO_SPI: begin
                if (cnt_q >= SWITCH_LAST) state_d = pd_q ? POWER_DOWN : SPI_HOLD;
            end
            SPI_HOLD: begin
                if (pd_q)          state_d = POWER_DOWN;
                else if (!rd_q)    state_d = SWITCH_BACK;
            end
            POWER_DOWN: state_d = OFF;
            OFF: begin
                if (!pd_q)         state_d = POWER_UP;
            end
            POWER_UP: begin
                if (pd_q) begin
                    state_d = POWER_DOWN;
                end else if (lk_q) begin
                    state_d = LOCK_SETTLE;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    lock_error_d = 1'b1;
                    state_d      = POWER_DOWN;
                end
            end
            LOCK_SETTLE: begin
                if (pd_q) begin
                    state_d = POWER_DOWN;
                end else if (!lk_q) begin
                    state_d = POWER_UP;
                end else if (cnt_q >= SETTLE_LAST) begin
                    lock_error_d = 1'b0;
                    state_d      = rd_q ? SPI_HOLD : SWITCH_BACK;
                end
            end
            SWITCH_BACK: begin
                if (pd_q || rd_q)               state_d = SWITCH_TO_SPI;
                else if (cnt_q >= SWITCH_LAST)  state_d = RUN;
            end
            default: state_d = POWER_UP;
        endcase

        // Shared counter restarts on every transition and saturates instead of wrapping.
        if (state_d != state_q)      cnt_d = '0;
        else if (cnt_q == CNT_MAX)   cnt_d = cnt_q;
        else                         cnt_d = cnt_q + CNT_W'(1);

        // Outputs are decoded from the next state so their flops track state_q exactly.
        pllpowerdown_n_d = !((state_d == POWER_DOWN) || (state_d == OFF));
        clock_select_d   = !((state_d == RUN) || (state_d == SWITCH_BACK));
        ready_d          = (state_d == RUN);
    end

    assign pllpowerdown_n_out = pllpowerdown_n_q;
    assign clock_select_out   = clock_select_q;
    assign ready_out          = ready_q;
    assign lock_error_out     = lock_error_q;
    assign state_out          = 3'(state_q);

endmodule

// File: doc/pll_power_sequencer.md
PLL_POWER_SEQUENCER -- requirements
Module: pll_power_sequencer

Interface
REQ-001 SHALL have parameter SWITCH_CYCLES, default 8, clock-mux settle wait in osc_clock cycles.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 64, cycles pll_locked must stay high before the PLL clocks are reselected.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 4096, maximum POWER_UP cycles waiting for lock.
REQ-004 SHALL have port osc_clock_in, input, 1, free-running 18 MHz oscillator clock; the only clock.
REQ-005 SHALL have port pll_reset, input, 1, reset: pll_reset, asynchronous, active-high.
REQ-006 SHALL have port powerdown_req_in, input, 1, asynchronous PLL power-down request from the CSR (1 = off).
REQ-007 SHALL have port read_req_in, input, 1, asynchronous image-buffer read request (1 = SPI clock needed).
REQ-008 SHALL have port pll_locked_in, input, 1, asynchronous PLL lock flag.
REQ-009 SHALL have port pllpowerdown_n_out, output, 1, PLL power enable (0 = powered down).
REQ-010 SHALL have port clock_select_out, output, 1, DCS select (0 = jpeg_clock, 1 = spi_clock).
REQ-011 SHALL have port ready_out, output, 1, high only in RUN.
REQ-012 SHALL have port lock_error_out, output, 1, sticky lock-timeout flag.
REQ-013 SHALL have port state_out, output, 3, current state encoding.

Function
REQ-014 SHALL pass powerdown_req_in, read_req_in, pll_locked_in through 2-flop synchronisers; all decisions use synchronised copies (pd, rd, lk).
REQ-015 SHALL implement states RUN=0, SWITCH_TO_SPI=1, SPI_HOLD=2, POWER_DOWN=3, OFF=4, POWER_UP=5, LOCK_SETTLE=6, SWITCH_BACK=7.
REQ-016 SHALL in RUN: pd or rd -> SWITCH_TO_SPI; else lk==0 -> POWER_UP with clock_select_out=1 from the next cycle (lock-loss recovery); pd takes priority over lock loss.
REQ-017 SHALL in SWITCH_TO_SPI hold clock_select_out=1 for SWITCH_CYCLES cycles, then go to POWER_DOWN if pd, else SPI_HOLD.
REQ-018 SHALL in SPI_HOLD: pd -> POWER_DOWN; rd==0 -> SWITCH_BACK; else remain.
REQ-019 SHALL in POWER_DOWN drive pllpowerdown_n_out=0 and go to OFF next cycle.
REQ-020 SHALL in OFF stay while pd==1; pd==0 -> POWER_UP.
REQ-021 SHALL in POWER_UP drive pllpowerdown_n_out=1 and count; lk==1 -> LOCK_SETTLE; count reaching LOCK_TIMEOUT -> set lock_error_out, go to POWER_DOWN (retry); pd==1 -> POWER_DOWN.
REQ-022 SHALL in LOCK_SETTLE require lk high for SETTLE_CYCLES consecutive cycles; lk low restarts POWER_UP with counter cleared; pd==1 -> POWER_DOWN; on completion go to SPI_HOLD if rd, else SWITCH_BACK.
REQ-023 SHALL in SWITCH_BACK drive clock_select_out=0 for SWITCH_CYCLES cycles, then RUN; pd or rd during SWITCH_BACK -> SWITCH_TO_SPI.
REQ-024 SHALL drive clock_select_out=1 in all states except RUN and SWITCH_BACK; pllpowerdown_n_out=0 only in POWER_DOWN and OFF.
REQ-025 SHALL use one shared counter, cleared on every state change, width ceil(log2(max parameter+1)), saturating (never wraps).
REQ-026 SHALL clear lock_error_out on the cycle LOCK_SETTLE completes; it is otherwise sticky.
REQ-027 SHALL register all outputs; state_out equals the current state register.
REQ-028 SHALL never assert clock_select_out=0 while pllpowerdown_n_out=0 or before LOCK_SETTLE has completed since last power-up.

Reset
REQ-029 SHALL, while pll_reset=1, force state POWER_UP, counter 0, synchroniser flops 0, pllpowerdown_n_out=1, clock_select_out=1, ready_out=0, lock_error_out=0, state_out=5.
REQ-030 SHALL release reset synchronously to osc_clock_in; reset mid-sequence (any state) discards in-progress counts.

Verification
REQ-031 Reset release, lk rises at cycle 10 -> LOCK_SETTLE, after 64 stable cycles SWITCH_BACK, clock_select_out=0, RUN and ready_out=1 after 8 more cycles.
REQ-032 In RUN assert powerdown_req_in -> clock_select_out=1 two sync cycles later, pllpowerdown_n_out=0 after 8 cycles, state_out=4; deassert -> full power-up back to RUN.
REQ-033 In RUN pulse read_req_in high 100 cycles -> SPI_HOLD with pllpowerdown_n_out=1 throughout, then SWITCH_BACK, RUN.
REQ-034 Hold pll_locked_in=0 after power-up -> lock_error_out=1 at cycle 4096, POWER_DOWN one cycle, retry POWER_UP; later lock clears flag.
REQ-035 Glitch pll_locked_in low 1 synchronised cycle at LOCK_SETTLE count 40 -> return to POWER_UP, settle count restarts from 0.
REQ-036 Assert pll_reset while in OFF -> outputs take REQ-029 values immediately, asynchronously.
